hack_spi_mem_target: RTL and testbench
======================================

HACK_SPI_MEM_TARGET -- requirements
Module: hack_spi_mem_target

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all logic on its rising edge.
REQ-002 SHALL have port resetb, input, 1 bit: reset, synchronous, active-low.
REQ-003 SHALL have port sclk_i, input, 1 bit: serial clock from the CPU memory master (SPI mode 0), asynchronous to clk.
REQ-004 SHALL have port csb_i, input, 1 bit: chip select, active-low, asynchronous.
REQ-005 SHALL have port mosi_i, input, 1 bit: serial data from the master, MSB first.
REQ-006 SHALL have port miso_o, output, 1 bit: serial data to the master, MSB first.
REQ-007 SHALL have port mem_addr_o, output, 15 bits: word address to the backing store.
REQ-008 SHALL have port mem_wdata_o, output, 16 bits: write data.
REQ-009 SHALL have port mem_we_o, output, 1 bit: one-cycle write strobe.
REQ-010 SHALL have port mem_re_o, output, 1 bit: one-cycle read strobe.
REQ-011 SHALL have port mem_rdata_i, input, 16 bits: read data, valid exactly one clk after mem_re_o.
REQ-012 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth on sclk_i, csb_i and mosi_i.

Function
REQ-013 SHALL pass sclk_i, csb_i and mosi_i through SYNC_STAGES flops, then detect sclk rise and fall edges from the synchronized values; the legal range is f_sclk <= f_clk/8.
REQ-014 SHALL use FSM states IDLE, CMD, ADDR, READ, WRITE, IGNORE.
REQ-015 SHALL transition IDLE->CMD when synchronized csb falls; bit counter cleared.
REQ-016 SHALL sample mosi on each sclk rise; in CMD, after 8 bits, go 0x03->ADDR(read), 0x02->ADDR(write), any other value->IGNORE.
REQ-017 SHALL in ADDR, shift 16 bits; the address register takes bits [14:0] and discards bit 15.
REQ-018 SHALL for a read, assert mem_re_o for one cycle on the clk after the 16th address bit is sampled, load mem_rdata_i into the tx shifter on the following clk, and present its MSB on miso_o at the next sclk fall.
REQ-019 SHALL in READ, shift the tx shifter out on each sclk fall; after 16 bits, increment the address, issue mem_re_o, and reload so that word-to-word output is gapless.
REQ-020 SHALL in WRITE, assemble 16 mosi bits; on the 16th rise, drive mem_wdata_o, assert mem_we_o for one cycle, then increment the address.
REQ-021 SHALL wrap the address increment from 0x7FFF to 0x0000.
REQ-022 SHALL when a partial write word is pending at csb rise, discard it without asserting mem_we_o.
REQ-023 SHALL hold miso_o at 0 in all states except READ.
REQ-024 SHALL return to IDLE within one clk of synchronized csb rising, from any state, and drop the in-flight word.
REQ-025 SHALL ignore sclk edges while csb is high.
REQ-026 SHALL give priority to csb rise when it coincides with an sclk edge; that edge is ignored.
REQ-027 SHALL never assert mem_we_o and mem_re_o in the same cycle.

Reset
REQ-028 SHALL while resetb is low at a clk edge, set state=IDLE, counters=0, address=0, shifters=0, miso_o=0, mem_we_o=0, mem_re_o=0, mem_addr_o=0, mem_wdata_o=0, and synchronizer flops to idle levels (csb=1, sclk=0, mosi=0).
REQ-029 SHALL after reset release, not start a transaction until a csb fall is seen; a transaction already in progress when reset releases is treated as IGNORE until csb rises.

Structure
REQ-030 SHALL take the command opcodes (CMD_READ=8'h03, CMD_WRITE=8'h02), the FSM state enum, and the address and data widths from the shared package hack_spi_pkg, which the CPU-side memory master also uses.
REQ-031 SHALL implement the synchronizer-plus-edge-detector as one sub-module, spi_sync_edge, instantiated once per input pin.

Verification
REQ-032 SHALL verify single read: cmd 0x03, addr 0x0010, stubbed mem[0x0010]=0xBEEF -> miso yields 0xBEEF MSB-first, exactly one mem_re_o with mem_addr_o=0x0010.
REQ-033 SHALL verify burst write: cmd 0x02, addr 0x7FFF, words 0x1234, 0xABCD -> mem_we_o pulses at 0x7FFF/0x1234 then 0x0000/0xABCD.
REQ-034 SHALL verify abort: write of 0x5555 with csb raised after 9 data bits -> no mem_we_o; the next read transaction works normally.
REQ-035 SHALL verify bad command: cmd 0xFF plus 32 clocks -> no strobes, miso stays 0, FSM back in IDLE after csb rises.
REQ-036 SHALL verify reset mid-read: resetb low during the second data word -> all outputs at reset values; the transaction is ignored until csb rises.
REQ-037 SHALL verify rate limit: every scenario above passes at f_sclk = f_clk/8 with random sclk phase relative to clk.

Source files
------------

// File: rtl/hack_spi_pkg.sv
// Shared definitions for the SPI memory target and the CPU-side master:
// opcodes, FSM states, address/data widths.
package hack_spi_pkg;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 16;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRITE = 8'h02;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        READ,
        WRITE,
        IGNORE
    } state_t;

    // Word address increment; wraps naturally at the top of the space.
    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
        return a + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with rise/fall detection on the synchronized value.
// Reset loads the pin's idle level so no spurious edge follows reset.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic resetb,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    always_ff @(posedge clk) begin
        if (!resetb) begin
            r_sync <= {STAGES{RST_VAL}};
            r_prev <= RST_VAL;
        end else begin
            r_sync <= (r_sync << 1) | STAGES'(i_d);
            r_prev <= o_q;
        end
    end

    assign o_q    = r_sync[STAGES-1];
    assign o_rise = o_q & ~r_prev;
    assign o_fall = ~o_q & r_prev;

endmodule

// File: rtl/hack_spi_mem_target.sv
// SPI mode-0 memory target: command/address decode and gapless word
// streaming to a synchronous backing store with one-cycle read latency.
module hack_spi_mem_target
    import hack_spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              resetb,
    input  logic              sclk_i,
    input  logic              csb_i,
    input  logic              mosi_i,
    output logic              miso_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_we_o,
    output logic              mem_re_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam logic [4:0] FLUSH_DONE = 5'(SYNC_STAGES + 1);

    logic w_sclk_s, w_sclk_rise, w_sclk_fall;
    logic w_csb_s, w_csb_rise, w_csb_fall;
    logic w_mosi_s, w_mosi_rise, w_mosi_fall;
    logic w_armed;
    logic w_unused;
    logic [DATA_W-1:0] w_rx_next;

    state_t            r_state;
    logic [4:0]        r_flush;
    logic [3:0]        r_bit_cnt;
    logic [DATA_W-2:0] r_rx;
    logic [DATA_W-1:0] r_tx;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_is_read;
    logic              r_we;
    logic              r_re;
    logic              r_load;
    logic              r_miso;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .clk(clk), .resetb(resetb), .i_d(sclk_i),
        .o_q(w_sclk_s), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_csb (
        .clk(clk), .resetb(resetb), .i_d(csb_i),
        .o_q(w_csb_s), .o_rise(w_csb_rise), .o_fall(w_csb_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
        .clk(clk), .resetb(resetb), .i_d(mosi_i),
        .o_q(w_mosi_s), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
    );

    assign w_unused  = &{1'b0, w_sclk_s, w_mosi_rise, w_mosi_fall};
    assign w_rx_next = {r_rx, w_mosi_s};
    // Until the chains have flushed real pin levels, a low csb means the
    // master was already mid-transaction at reset release.
    assign w_armed   = (r_flush == FLUSH_DONE);

    always_ff @(posedge clk) begin
        if (!resetb) begin
            r_state   <= IDLE;
            r_flush   <= '0;
            r_bit_cnt <= '0;
            r_rx      <= '0;
            r_tx      <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_is_read <= 1'b0;
            r_we      <= 1'b0;
            r_re      <= 1'b0;
            r_load    <= 1'b0;
            r_miso    <= 1'b0;
        end else begin
            r_we   <= 1'b0;
            r_re   <= 1'b0;
            r_load <= r_re;
            if (!w_armed) r_flush <= r_flush + 5'd1;
            if (r_we) r_addr <= addr_inc(r_addr);
            if (r_load && r_state == READ) r_tx <= mem_rdata_i;
            if (w_csb_rise) begin
                r_state   <= IDLE;
                r_bit_cnt <= '0;
                r_rx      <= '0;
                r_tx      <= '0;
                r_load    <= 1'b0;
                r_miso    <= 1'b0;
            end else begin
                unique case (r_state)
                    IDLE: begin
                        r_bit_cnt <= '0;
                        if (w_csb_fall && w_armed) r_state <= CMD;
                        else if (!w_csb_s)         r_state <= IGNORE;
                    end
                    CMD: if (w_sclk_rise) begin
                        r_rx      <= w_rx_next[DATA_W-2:0];
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        if (r_bit_cnt == 4'd7) begin
                            r_bit_cnt <= '0;
                            r_is_read <= (w_rx_next[7:0] == CMD_READ);
                            if (w_rx_next[7:0] == CMD_READ ||
                                w_rx_next[7:0] == CMD_WRITE)
                                r_state <= ADDR;
                            else
                                r_state <= IGNORE;
                        end
                    end
                    ADDR: if (w_sclk_rise) begin
                        r_rx      <= w_rx_next[DATA_W-2:0];
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        if (r_bit_cnt == 4'd15) begin
                            r_bit_cnt <= '0;
                            r_addr    <= w_rx_next[ADDR_W-1:0];
                            r_re      <= r_is_read;
                            r_state   <= r_is_read ? READ : WRITE;
                        end
                    end
                    READ: if (w_sclk_fall) begin
                        r_miso    <= r_tx[DATA_W-1];
                        r_tx      <= {r_tx[DATA_W-2:0], 1'b0};
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        if (r_bit_cnt == 4'd15) begin
                            r_bit_cnt <= '0;
                            r_addr    <= addr_inc(r_addr);
                            r_re      <= 1'b1;
                        end
                    end
                    WRITE: if (w_sclk_rise) begin
                        r_rx      <= w_rx_next[DATA_W-2:0];
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        if (r_bit_cnt == 4'd15) begin
                            r_bit_cnt <= '0;
                            r_wdata   <= w_rx_next;
                            r_we      <= 1'b1;
                        end
                    end
                    IGNORE: r_bit_cnt <= '0;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign miso_o      = r_miso;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;
    assign mem_we_o    = r_we;
    assign mem_re_o    = r_re;

endmodule

// File: tb/tb_hack_spi_mem_target.sv
// Directed bench for hack_spi_mem_target: SPI master at f_clk/8 with random
// phase, stub memory, and write/read scoreboards.
module tb_hack_spi_mem_target;

    localparam int         HALF   = 40;
    localparam logic [7:0] OP_RD  = 8'h03;
    localparam logic [7:0] OP_WR  = 8'h02;

    logic        clk;
    logic        resetb;
    logic        sclk;
    logic        csb;
    logic        mosi;
    logic        miso;
    logic [14:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [15:0] mem_rdata;

    logic [15:0] mem     [0:32767];
    bit          written [0:32767];

    int          n_vec;
    int          n_err;
    int          we_cnt;
    logic [31:0] exp_wr [$];
    logic [15:0] exp_rd [$];
    logic [14:0] re_log [$];
    logic [15:0] quiet;

    hack_spi_mem_target dut (
        .clk         (clk),
        .resetb      (resetb),
        .sclk_i      (sclk),
        .csb_i       (csb),
        .mosi_i      (mosi),
        .miso_o      (miso),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_we_o    (mem_we),
        .mem_re_o    (mem_re),
        .mem_rdata_i (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] preset(input logic [14:0] a);
        case (a)
            15'h0010: return 16'hBEEF;
            15'h0011: return 16'hCAFE;
            15'h7FFF: return 16'h1111;
            15'h0000: return 16'h2222;
            default:  return 16'h0000;
        endcase
    endfunction

    always @(posedge clk) begin
        if (mem_re)
            mem_rdata <= written[mem_addr] ? mem[mem_addr] : preset(mem_addr);
        if (mem_we) begin
            mem[mem_addr]     <= mem_wdata;
            written[mem_addr] <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_we || mem_re)
            check("we_re_excl", 32'(mem_we & mem_re), 32'd0);
        if (mem_re) re_log.push_back(mem_addr);
        if (mem_we) begin
            we_cnt++;
            n_vec++;
            assert (exp_wr.size() != 0) else begin
                n_err++;
                $error("FAIL wr_unexpected: observed %h/%h expected none",
                       mem_addr, mem_wdata);
            end
            if (exp_wr.size() != 0)
                check("wr", {1'b0, mem_addr, mem_wdata}, exp_wr.pop_front());
        end
    end

    task automatic spi_bits(input logic [15:0] v, input int n,
                            output logic [15:0] got);
        got = '0;
        for (int i = n - 1; i >= 0; i--) begin
            mosi = v[i];
            #HALF;
            got  = {got[14:0], miso};
            sclk = 1'b1;
            #HALF;
            sclk = 1'b0;
        end
    endtask

    task automatic cs_low();
        @(posedge clk);
        #($urandom_range(1, 9));
        csb = 1'b0;
    endtask

    task automatic cs_high();
        #HALF;
        csb  = 1'b1;
        mosi = 1'b0;
        repeat (12) @(posedge clk);
    endtask

    task automatic spi_hdr(input logic [7:0] c, input logic [14:0] a);
        logic [15:0] g;
        cs_low();
        spi_bits({8'h00, c}, 8, g);
        quiet = g;
        spi_bits({1'b1, a}, 16, g);
        quiet |= g;
    endtask

    task automatic read_words(input int nw);
        logic [15:0] got;
        for (int k = 0; k < nw; k++) begin
            spi_bits(16'h0000, 16, got);
            n_vec++;
            assert (exp_rd.size() != 0) else begin
                n_err++;
                $error("FAIL rd_unexpected: observed %h expected none", got);
            end
            if (exp_rd.size() != 0)
                check("rd", 32'(got), 32'(exp_rd.pop_front()));
        end
    endtask

    function automatic int count_re(input int from, input logic [14:0] a);
        int c = 0;
        for (int i = from; i < re_log.size(); i++)
            if (re_log[i] == a) c++;
        return c;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_miso"},  32'(miso),      32'd0);
        check({tag, "_we"},    32'(mem_we),    32'd0);
        check({tag, "_re"},    32'(mem_re),    32'd0);
        check({tag, "_addr"},  32'(mem_addr),  32'd0);
        check({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          b;
        int          w;
        logic [15:0] g;
        n_vec  = 0;
        n_err  = 0;
        we_cnt = 0;
        resetb = 1'b0;
        csb    = 1'b1;
        sclk   = 1'b0;
        mosi   = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        resetb = 1'b1;
        repeat (10) @(posedge clk);

        // single read
        b = re_log.size();
        exp_rd.push_back(16'hBEEF);
        spi_hdr(OP_RD, 15'h0010);
        read_words(1);
        cs_high();
        check("rd_hdr_quiet", 32'(quiet), 32'd0);
        check("rd_re_cnt", 32'(count_re(b, 15'h0010)), 32'd1);
        check("rd_re_addr", 32'(re_log[b]), 32'h0010);

        // burst read across the address wrap
        b = re_log.size();
        exp_rd.push_back(16'h1111);
        exp_rd.push_back(16'h2222);
        spi_hdr(OP_RD, 15'h7FFF);
        read_words(2);
        cs_high();
        check("brd_re0", 32'(re_log[b]), 32'h7FFF);
        check("brd_re1", 32'(re_log[b + 1]), 32'h0000);

        // burst write across the address wrap
        w = we_cnt;
        exp_wr.push_back({1'b0, 15'h7FFF, 16'h1234});
        exp_wr.push_back({1'b0, 15'h0000, 16'hABCD});
        spi_hdr(OP_WR, 15'h7FFF);
        spi_bits(16'h1234, 16, g);
        spi_bits(16'hABCD, 16, g);
        cs_high();
        check("bwr_cnt", 32'(we_cnt - w), 32'd2);
        check("bwr_drained", 32'(exp_wr.size()), 32'd0);
        check("mem_7fff", 32'(mem[15'h7FFF]), 32'h1234);
        check("mem_0000", 32'(mem[15'h0000]), 32'hABCD);

        // abort after 9 data bits
        w = we_cnt;
        spi_hdr(OP_WR, 15'h0100);
        spi_bits(16'h5555 >> 7, 9, g);
        cs_high();
        check("abort_no_we", 32'(we_cnt - w), 32'd0);
        exp_rd.push_back(16'hBEEF);
        spi_hdr(OP_RD, 15'h0010);
        read_words(1);
        cs_high();

        // unknown opcode
        w = we_cnt;
        b = re_log.size();
        cs_low();
        spi_bits(16'h00FF, 8, g);
        quiet = g;
        spi_bits(16'hFFFF, 16, g);
        quiet |= g;
        spi_bits(16'hFFFF, 16, g);
        quiet |= g;
        cs_high();
        check("bad_quiet", 32'(quiet), 32'd0);
        check("bad_no_we", 32'(we_cnt - w), 32'd0);
        check("bad_no_re", 32'(re_log.size() - b), 32'd0);
        exp_rd.push_back(16'hCAFE);
        spi_hdr(OP_RD, 15'h0011);
        read_words(1);
        cs_high();

        // reset during the second word of a read burst
        exp_rd.push_back(16'hBEEF);
        spi_hdr(OP_RD, 15'h0010);
        read_words(1);
        spi_bits(16'h0000, 4, g);
        @(negedge clk);
        resetb = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("mid_rst");
        w = we_cnt;
        b = re_log.size();
        resetb = 1'b1;
        spi_bits(16'h0000, 12, g);
        quiet = g;
        spi_bits(16'h0000, 16, g);
        quiet |= g;
        cs_high();
        check("mid_rst_quiet", 32'(quiet), 32'd0);
        check("mid_rst_no_re", 32'(re_log.size() - b), 32'd0);
        check("mid_rst_no_we", 32'(we_cnt - w), 32'd0);
        exp_rd.push_back(16'hCAFE);
        spi_hdr(OP_RD, 15'h0011);
        read_words(1);
        cs_high();
        check("rd_drained", 32'(exp_rd.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
